// File: rtl/uart_axi_fifo_if.sv
// rtl/uart_axi_fifo_if.sv - AXI4-lite-style bus (with ID/RLAST) between crossbar and UART
interface uart_axi_fifo_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (
    output arvalid, araddr, arid, rready, awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, rid, rlast, awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  arvalid, araddr, arid, rready, awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, rid, rlast, awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/uart_axi_fifo.sv
// rtl/uart_axi_fifo.sv - bus slave with register map, TX byte FIFO and 8N1 transmitter
module uart_axi_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 16,
  parameter int SIM_PRINT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_axi_fifo_if.slave  bus,
  output logic            tx,
  output logic            tx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t         state, state_n;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              empty, full, push, pop;
  logic [DIV_W-1:0]  div, div_wr, period, cyc;
  logic [7:0]        shift;
  logic [2:0]        bit_cnt;
  logic              bit_end;

  logic              aw_seen, w_seen, aw_fire, w_fire, do_wr, push_req;
  logic [1:0]        aw_sel_q, wr_sel;
  logic [3:0]        awid_q, wr_id, wstrb_q, wr_strb;
  logic [31:0]       wdata_q, wr_data, bmask, rd_data;
  logic [1:0]        rd_resp;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign tx_busy = (state != IDLE);

  assign bus.arready = !bus.rvalid;
  assign bus.rlast   = bus.rvalid;
  assign bus.awready = !bus.bvalid && !aw_seen;
  assign bus.wready  = !bus.bvalid && !w_seen;

  assign aw_fire  = bus.awvalid && bus.awready;
  assign w_fire   = bus.wvalid && bus.wready;
  assign wr_sel   = aw_seen ? aw_sel_q : bus.awaddr[3:2];
  assign wr_id    = aw_seen ? awid_q   : bus.awid;
  assign wr_data  = w_seen  ? wdata_q  : bus.wdata;
  assign wr_strb  = w_seen  ? wstrb_q  : bus.wstrb;
  assign do_wr    = (aw_seen || aw_fire) && (w_seen || w_fire) && !bus.bvalid;
  assign push_req = do_wr && (wr_sel == 2'd0) && wr_strb[0];
  assign push     = push_req && !full;

  assign bmask  = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
  assign div_wr = (div & ~bmask[DIV_W-1:0]) | (wr_data[DIV_W-1:0] & bmask[DIV_W-1:0]);

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (bus.araddr[3:2])
      2'd1: begin
        rd_data[0]      = empty;
        rd_data[1]      = full;
        rd_data[2]      = tx_busy;
        rd_data[8 +: CW] = count;
      end
      2'd2:    rd_data[DIV_W-1:0] = div;
      2'd3:    rd_resp = RESP_SLVERR;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.rresp  <= RESP_OKAY;
      bus.rid    <= '0;
      bus.bvalid <= 1'b0;
      bus.bresp  <= RESP_OKAY;
      bus.bid    <= '0;
      aw_seen    <= 1'b0;
      w_seen     <= 1'b0;
      aw_sel_q   <= '0;
      awid_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      div        <= DIV_W'(DIV_RESET);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= rd_data;
        bus.rresp  <= rd_resp;
        bus.rid    <= bus.arid;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end

      if (do_wr) begin
        aw_seen    <= 1'b0;
        w_seen     <= 1'b0;
        bus.bvalid <= 1'b1;
        bus.bid    <= wr_id;
        bus.bresp  <= ((wr_sel == 2'd3) || (push_req && full)) ? RESP_SLVERR : RESP_OKAY;
        if (wr_sel == 2'd2) div <= div_wr;
      end else begin
        if (aw_fire) begin
          aw_seen  <= 1'b1;
          aw_sel_q <= bus.awaddr[3:2];
          awid_q   <= bus.awid;
        end
        if (w_fire) begin
          w_seen  <= 1'b1;
          wdata_q <= bus.wdata;
          wstrb_q <= bus.wstrb;
        end
        if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      end

      if (push) begin
        mem[wr_ptr] <= wr_data[7:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Bit period is frozen at pop time so DIV writes only affect later frames.
  assign bit_end = (cyc == period - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_n = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (bit_end && bit_cnt == 3'd7) state_n = STOP;
      end
      STOP: if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift   <= '0;
      bit_cnt <= '0;
      cyc     <= '0;
      period  <= DIV_W'(1);
    end else if (pop) begin
      shift   <= mem[rd_ptr];
      bit_cnt <= '0;
      cyc     <= '0;
      period  <= (div == '0) ? DIV_W'(1) : div;
    end else if (state != IDLE) begin
      if (bit_end) begin
        cyc <= '0;
        if (state == DATA) begin
          shift   <= {1'b0, shift[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        cyc <= cyc + 1'b1;
      end
    end
  end

  generate
    if (SIM_PRINT != 0) begin : g_sim_print
      always_ff @(posedge clk) begin
        if (rst && push) begin
          $write("%c", wr_data[7:0]);
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_uart_axi_fifo.sv
// tb/tb_uart_axi_fifo.sv - randomized self-checking bench against a register/FIFO/8N1 model
module tb_uart_axi_fifo;
  localparam int DEPTH = 16;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, tx_busy;
  int   checks = 0;
  int   errors = 0;
  int   model_div = 16;

  uart_axi_fifo_if bus ();

  uart_axi_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DIV_RESET(16), .SIM_PRINT(0)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id,
                          output logic [31:0] data, output logic [1:0] resp,
                          output logic [3:0] rid_o, output logic last);
    int n = 0;
    bus.araddr = addr; bus.arid = id; bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    while (bus.rvalid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h got rvalid=%b want 1", addr, bus.rvalid);
    end
    data = bus.rdata; resp = bus.rresp; rid_o = bus.rid; last = bus.rlast;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  // mode 0: AW and W together, 1: AW one cycle before W, 2: W one cycle before AW
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [3:0] id, input int mode,
                           output logic [1:0] resp, output logic [3:0] bid_o);
    int n = 0;
    logic aw_left = 1'b1, w_left = 1'b1, af, wf;
    bus.awaddr = addr; bus.awid = id; bus.wdata = data; bus.wstrb = strb;
    while ((aw_left || w_left) && n < 50) begin
      if (aw_left && (mode != 2 || n >= 1)) bus.awvalid = 1'b1;
      if (w_left && (mode != 1 || n >= 1)) bus.wvalid = 1'b1;
      af = bus.awvalid && bus.awready;
      wf = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (af) begin bus.awvalid = 1'b0; aw_left = 1'b0; end
      if (wf) begin bus.wvalid = 1'b0; w_left = 1'b0; end
      n++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    while (bus.bvalid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h got bvalid=%b want 1", addr, bus.bvalid);
    end
    resp = bus.bresp; bid_o = bus.bid;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  // Watches tx for one 8N1 frame of byte b with bit period p; bad<0 means no start bit seen.
  task automatic watch_frame(input logic [7:0] b, input int p, output int bad);
    int k = 0;
    int idx;
    logic want;
    bad = 0;
    while (tx !== 1'b0 && k < 400) begin @(posedge clk); #1; k++; end
    if (k >= 400) begin bad = -1; return; end
    for (int c = 0; c < 10 * p; c++) begin
      idx  = c / p;
      want = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : b[idx-1];
      if (tx !== want || tx_busy !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
  endtask

  function automatic int div_after_write(int old, logic [31:0] data, logic [3:0] strb);
    int r = old;
    for (int b = 0; b < 2; b++)
      if (strb[b]) r = (r & ~(32'hFF << (8 * b))) | (int'(data) & (32'hFF << (8 * b)));
    return r & 32'hFFFF;
  endfunction

  task automatic test_reset;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0 ||
        bus.rdata !== 32'h0 || bus.rresp !== 2'b00 || bus.rid !== 4'h0 ||
        bus.bresp !== 2'b00 || bus.bid !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs got tx=%b busy=%b rvalid=%b bvalid=%b rdata=%h bid=%h want 1 0 0 0 0 0",
               tx, tx_busy, bus.rvalid, bus.bvalid, bus.rdata, bus.bid);
    end
    #3 rst = 1'b1;
    @(posedge clk); #1;
    begin
      logic [31:0] d; logic [1:0] r; logic [3:0] i; logic l;
      axi_read(32'h4, 4'h3, d, r, i, l);
      checks++;
      if (d !== 32'h1 || r !== OKAY) begin
        errors++;
        $display("FAIL reset_status got %h/%b want 00000001/00", d, r);
      end
    end
  endtask

  task automatic test_div_rw;
    logic [31:0] d, wd; logic [1:0] r; logic [3:0] i, id, st; logic l;
    id = 4'($urandom);
    axi_read(32'h8, id, d, r, i, l);
    checks++;
    if (d !== 32'(model_div) || r !== OKAY || i !== id || l !== 1'b1) begin
      errors++;
      $display("FAIL div_reset_read got %h rid=%h rlast=%b want %h rid=%h rlast=1", d, i, l, model_div, id);
    end
    axi_write(32'h8, 32'h20, 4'b0001, 4'h5, 0, r, i);
    model_div = div_after_write(model_div, 32'h20, 4'b0001);
    id = 4'($urandom);
    axi_read(32'h8, id, d, r, i, l);
    checks++;
    if (d !== 32'h20 || i !== id || l !== 1'b1) begin
      errors++;
      $display("FAIL div_write_read got %h rid=%h rlast=%b want 00000020 rid=%h rlast=1", d, i, l, id);
    end
    for (int n = 0; n < 3; n++) begin
      wd = $urandom; st = 4'($urandom);
      axi_write({$urandom, 4'h8}, wd, st, 4'h1, n, r, i);
      model_div = div_after_write(model_div, wd, st);
      axi_read(32'h8, 4'h2, d, r, i, l);
      checks++;
      if (d !== 32'(model_div)) begin
        errors++;
        $display("FAIL div_masked_write strb=%b got %h want %h", st, d, model_div);
      end
    end
  endtask

  task automatic test_frame(input logic [7:0] b, input int div, input int mode, input string nm);
    logic [1:0] r; logic [3:0] i, id; int bad; int p;
    axi_write(32'h8, 32'(div), 4'hF, 4'h0, 0, r, i);
    model_div = div;
    p  = (div == 0) ? 1 : div;
    id = 4'($urandom);
    fork
      axi_write({$urandom, 4'h0}, {24'($urandom), b}, 4'($urandom) | 4'b0001, id, mode, r, i);
      watch_frame(b, p, bad);
    join
    checks++;
    if (r !== OKAY || i !== id) begin
      errors++;
      $display("FAIL %s_bresp got resp=%b bid=%h want 00 bid=%h", nm, r, i, id);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_waveform byte=%h P=%0d got %0d bad cycles want 0", nm, b, p, bad);
    end
  endtask

  task automatic test_frames_random;
    for (int n = 0; n < 4; n++)
      test_frame(8'($urandom), $urandom_range(0, 6), $urandom_range(0, 2), "frame_rand");
  endtask

  task automatic test_unmapped;
    logic [31:0] d; logic [1:0] r; logic [3:0] i, id; logic l;
    id = 4'($urandom);
    axi_read({$urandom, 4'hC}, id, d, r, i, l);
    checks++;
    if (d !== 32'h0 || r !== SLVERR || i !== id) begin
      errors++;
      $display("FAIL unmapped_read got %h/%b rid=%h want 00000000/10 rid=%h", d, r, i, id);
    end
    axi_write(32'hC, $urandom, 4'hF, id, 1, r, i);
    checks++;
    if (r !== SLVERR || i !== id) begin
      errors++;
      $display("FAIL unmapped_write got %b bid=%h want 10 bid=%h", r, i, id);
    end
    axi_read(32'h0, 4'h1, d, r, i, l);
    checks++;
    if (d !== 32'h0 || r !== OKAY) begin
      errors++;
      $display("FAIL txdata_read got %h/%b want 00000000/00", d, r);
    end
    axi_write(32'h4, 32'hFFFF_FFFF, 4'hF, 4'h2, 2, r, i);
    checks++;
    if (r !== OKAY) begin
      errors++;
      $display("FAIL status_write got %b want 00", r);
    end
    axi_read(32'h4, 4'h1, d, r, i, l);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL unmapped_count got status %h want 00000001", d);
    end
    axi_read(32'h8, 4'h1, d, r, i, l);
    checks++;
    if (d !== 32'(model_div)) begin
      errors++;
      $display("FAIL unmapped_div got %h want %h", d, model_div);
    end
  endtask

  task automatic test_rready_hold;
    logic [31:0] d0; int n = 0; int bad = 0; logic [3:0] id2;
    id2 = 4'($urandom);
    bus.araddr = 32'h8; bus.arid = 4'h9; bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.araddr = 32'h4; bus.arid = id2;
    d0 = bus.rdata;
    checks++;
    if (d0 !== 32'(model_div) || bus.rid !== 4'h9) begin
      errors++;
      $display("FAIL hold_first_data got %h rid=%h want %h rid=9", d0, bus.rid, model_div);
    end
    for (int c = 0; c < 5; c++) begin
      if (bus.rvalid !== 1'b1 || bus.arready !== 1'b0 || bus.rdata !== d0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable got %0d unstable cycles want 0", bad);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release got rvalid=%b arready=%b want 0 1", bus.rvalid, bus.arready);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rid !== id2 || bus.rdata !== 32'h1) begin
      errors++;
      $display("FAIL hold_second_read got rvalid=%b rid=%h data=%h want 1 %h 00000001",
               bus.rvalid, bus.rid, bus.rdata, id2);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic test_fill;
    logic [31:0] d; logic [1:0] r, want; logic [3:0] i; logic l;
    int q = 0; int ok = 0; logic held = 1'b0; int want_status;
    axi_write(32'h8, 32'd1000, 4'hF, 4'h0, 0, r, i);
    model_div = 1000;
    for (int n = 0; n < DEPTH + 2; n++) begin
      want = (q < DEPTH) ? OKAY : SLVERR;
      axi_write(32'h0, {24'h0, 8'($urandom)}, 4'h1, 4'(n), $urandom_range(0, 2), r, i);
      if (want == OKAY) q++;
      if (!held && q > 0) begin q--; held = 1'b1; end
      if (r == OKAY) ok++;
      checks++;
      if (r !== want) begin
        errors++;
        $display("FAIL fill_push_%0d got %b want %b", n, r, want);
      end
    end
    checks++;
    if (ok != DEPTH + 1) begin
      errors++;
      $display("FAIL fill_ok_count got %0d want %0d", ok, DEPTH + 1);
    end
    want_status = (q << 8) | ((q == DEPTH) ? 2 : 0) | 4 | ((q == 0) ? 1 : 0);
    axi_read(32'h4, 4'h7, d, r, i, l);
    checks++;
    if (d !== 32'(want_status)) begin
      errors++;
      $display("FAIL fill_status got %h want %h", d, want_status);
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d; logic [1:0] r; logic [3:0] i; logic l;
    checks++;
    if (tx_busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL midframe_pre got busy=%b tx=%b want 1 0", tx_busy, tx);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset got tx=%b busy=%b rvalid=%b bvalid=%b want 1 0 0 0",
               tx, tx_busy, bus.rvalid, bus.bvalid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_div = 16;
    axi_read(32'h4, 4'h4, d, r, i, l);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL midframe_status got %h want 00000001", d);
    end
    axi_read(32'h8, 4'h4, d, r, i, l);
    checks++;
    if (d !== 32'(model_div)) begin
      errors++;
      $display("FAIL midframe_div got %h want %h", d, model_div);
    end
  endtask

  initial begin
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.rready = 1'b0;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_div_rw;
    test_frame(8'h55, 4, 1, "frame_55");
    test_frames_random;
    test_unmapped;
    test_rready_hold;
    test_fill;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
